// File: rtl/trig_counter_pkg.sv
// trig_counter_pkg: shared op encoding and limits for the trigger counter bank
package trig_counter_pkg;
  localparam int MAX_CH   = 16;
  localparam int RD_SEL_W = 8;
  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_UP   = 3'd3;
  localparam logic [2:0] OP_DOWN = 3'd4;
  function automatic logic [2:0] op_encode(input logic clr, input logic load, input logic up, input logic down);
    return clr ? OP_CLR : load ? OP_LOAD : (up & down) ? OP_HOLD : up ? OP_UP : down ? OP_DOWN : OP_HOLD;
  endfunction
endpackage

// File: rtl/trig_counter_ch.sv
// trig_counter_ch: one up/down counter with load, wrap/saturate and sticky overflow
module trig_counter_ch
  import trig_counter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_up,
  input  logic              i_down,
  input  logic              i_load,
  input  logic              i_sat_mode,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic [STEP_W-1:0] i_step,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_ovf
);
  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic [2:0]       w_op;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_ovf;
  assign w_op  = op_encode(i_clr, i_load, i_up, i_down);
  assign w_s   = (i_step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(i_step);
  assign w_sum = {1'b0, r_count} + w_s;
  assign w_dif = {1'b0, r_count} - w_s;
  // bit WIDTH of the extended result is the carry (up) or borrow (down)
  assign w_up_val = (w_sum[WIDTH] && i_sat_mode) ? '1 : w_sum[WIDTH-1:0];
  assign w_dn_val = (w_dif[WIDTH] && i_sat_mode) ? '0 : w_dif[WIDTH-1:0];
  always_comb begin
    w_nxt_count = (w_op == OP_CLR)  ? '0 :
                  (w_op == OP_LOAD) ? i_load_val :
                  (w_op == OP_UP)   ? w_up_val :
                  (w_op == OP_DOWN) ? w_dn_val : r_count;
    w_nxt_ovf   = (w_op == OP_CLR)  ? 1'b0 :
                  (w_op == OP_UP)   ? (r_ovf | w_sum[WIDTH]) :
                  (w_op == OP_DOWN) ? (r_ovf | w_dif[WIDTH]) : r_ovf;
  end
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_nxt_count;
      r_ovf   <= w_nxt_ovf;
    end
  end
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/trig_counter_bank.sv
// trig_counter_bank: N_CH trigger-driven counters with atomic snapshot bank and 16-bit readback mux
module trig_counter_bank
  import trig_counter_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       up,
  input  logic [N_CH-1:0]       down,
  input  logic [N_CH-1:0]       load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [STEP_W-1:0]     step,
  input  logic [N_CH-1:0]       sat_mode,
  input  logic                  snap,
  input  logic [RD_SEL_W-1:0]   rd_sel,
  output logic [15:0]           rd_data,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       ovf,
  output logic [N_CH-1:0]       snap_ovf,
  output logic                  snap_done
);
  localparam int NW = WIDTH / 16;
  logic [WIDTH-1:0] w_count [N_CH];
  logic [WIDTH-1:0] r_shadow [N_CH];
  logic [N_CH-1:0]  r_snap_ovf;
  logic             r_snap_done;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    trig_counter_ch #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_ch (
      .sys_clk    (sys_clk),
      .reset_n    (reset_n),
      .i_clr      (clr[i]),
      .i_up       (up[i]),
      .i_down     (down[i]),
      .i_load     (load[i]),
      .i_sat_mode (sat_mode[i]),
      .i_load_val (load_val),
      .i_step     (step),
      .o_count    (w_count[i]),
      .o_ovf      (ovf[i])
    );
    assign count[i*WIDTH +: WIDTH] = w_count[i];
  end
  // shadow samples the registered counts, so it sees pre-op values of this edge
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) r_shadow[c] <= '0;
      r_snap_ovf  <= '0;
      r_snap_done <= 1'b0;
    end else begin
      if (snap) begin
        for (int c = 0; c < N_CH; c++) r_shadow[c] <= w_count[c];
        r_snap_ovf <= ovf;
      end
      r_snap_done <= snap;
    end
  end
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N_CH; c++)
      for (int w = 0; w < NW; w++)
        if (rd_sel[7:4] == c[3:0] && rd_sel[3:0] == w[3:0]) rd_data = r_shadow[c][w*16 +: 16];
  end
  assign snap_ovf  = r_snap_ovf;
  assign snap_done = r_snap_done;
endmodule

// File: tb/tb_trig_counter_bank.sv
// tb_trig_counter_bank: directed vectors with hand-computed expectations for trig_counter_bank
module tb_trig_counter_bank;
  logic         sys_clk = 1'b0;
  logic         reset_n;
  logic [3:0]   clr, up, down, load, sat_mode, ovf, snap_ovf;
  logic [31:0]  load_val;
  logic [7:0]   step, rd_sel;
  logic         snap, snap_done;
  logic [15:0]  rd_data;
  logic [127:0] count;
  int n_chk = 0;
  int n_fail = 0;
  always #5 sys_clk = ~sys_clk;
  trig_counter_bank #(.N_CH(4), .WIDTH(32), .STEP_W(8)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .up        (up),
    .down      (down),
    .load      (load),
    .load_val  (load_val),
    .step      (step),
    .sat_mode  (sat_mode),
    .snap      (snap),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .count     (count),
    .ovf       (ovf),
    .snap_ovf  (snap_ovf),
    .snap_done (snap_done)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic ld(input int ch, input logic [31:0] val);
    load = 4'b0001 << ch;
    load_val = val;
    tick;
    load = '0;
  endtask
  task automatic rd(input string tag, input logic [7:0] sel, input logic [15:0] exp);
    rd_sel = sel;
    #1;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask
  initial begin
    reset_n = 1'b0; clr = '0; up = '0; down = '0; load = '0; load_val = '0;
    step = 8'd1; sat_mode = '0; snap = 1'b0; rd_sel = '0;
    #12;
    chk("rst_count_lo", count[63:0], 64'd0);
    chk("rst_count_hi", count[127:64], 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_snap_done", 64'(snap_done), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    reset_n = 1'b1;
    tick;
    ld(0, 32'hFFFF_FFFE);
    up = 4'b0001;
    tick;
    chk("wrap_up1", 64'(count[31:0]), 64'hFFFF_FFFF);
    chk("wrap_up1_ovf", 64'(ovf[0]), 64'd0);
    tick;
    chk("wrap_up2", 64'(count[31:0]), 64'd0);
    chk("wrap_up2_ovf", 64'(ovf[0]), 64'd1);
    tick;
    chk("wrap_up3", 64'(count[31:0]), 64'd1);
    chk("wrap_up3_ovf", 64'(ovf[0]), 64'd1);
    up = '0;
    sat_mode = 4'b0010;
    ld(1, 32'd5);
    step = 8'd8;
    down = 4'b0010;
    tick;
    down = '0;
    chk("sat_down", 64'(count[63:32]), 64'd0);
    chk("sat_down_ovf", 64'(ovf[1]), 64'd1);
    clr = 4'b0010;
    tick;
    clr = '0;
    chk("clr_ovf", 64'(ovf[1]), 64'd0);
    ld(1, 32'hFFFF_FFF7);
    up = 4'b0010;
    tick;
    chk("sat_exact", 64'(count[63:32]), 64'hFFFF_FFFF);
    chk("sat_exact_ovf", 64'(ovf[1]), 64'd0);
    tick;
    chk("sat_hold", 64'(count[63:32]), 64'hFFFF_FFFF);
    chk("sat_hold_ovf", 64'(ovf[1]), 64'd1);
    up = '0;
    step = 8'd0;
    ld(3, 32'd10);
    up = 4'b1000;
    tick;
    up = '0;
    chk("step0", 64'(count[127:96]), 64'd11);
    step = 8'd1;
    ld(2, 32'd7);
    up = 4'b0100; down = 4'b0100;
    tick;
    chk("updown_hold", 64'(count[95:64]), 64'd7);
    down = '0; clr = 4'b0100; load = 4'b0100; load_val = 32'd99;
    tick;
    clr = '0; load = '0; up = '0;
    chk("clr_prio", 64'(count[95:64]), 64'd0);
    clr = 4'b1110;
    tick;
    clr = '0;
    ld(0, 32'd10); ld(1, 32'd20); ld(2, 32'd30); ld(3, 32'd40);
    up = 4'hF; snap = 1'b1;
    tick;
    up = '0; snap = 1'b0;
    chk("snap_done_hi", 64'(snap_done), 64'd1);
    chk("live0", 64'(count[31:0]), 64'd11);
    chk("live1", 64'(count[63:32]), 64'd21);
    chk("live2", 64'(count[95:64]), 64'd31);
    chk("live3", 64'(count[127:96]), 64'd41);
    chk("snap_ovf", 64'(snap_ovf), 64'h1);
    rd("shadow0", 8'h00, 16'd10);
    rd("shadow1", 8'h10, 16'd20);
    rd("shadow2", 8'h20, 16'd30);
    rd("shadow3", 8'h30, 16'd40);
    rd("shadow0_hi", 8'h01, 16'd0);
    tick;
    chk("snap_done_lo", 64'(snap_done), 64'd0);
    ld(3, 32'hABCD_1234);
    snap = 1'b1; clr = 4'b1000;
    tick;
    snap = 1'b0; clr = '0;
    chk("snap_clr_live", 64'(count[127:96]), 64'd0);
    rd("rd_hi", 8'h31, 16'hABCD);
    rd("rd_lo", 8'h30, 16'h1234);
    rd("rd_bad_ch", 8'h50, 16'h0000);
    rd("rd_bad_word", 8'h04, 16'h0000);
    rd_sel = 8'h31;
    up = 4'hF;
    tick;
    tick;
    snap = 1'b1;
    tick;
    snap = 1'b0;
    chk("pre_rst_snap_done", 64'(snap_done), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count_lo", count[63:0], 64'd0);
    chk("arst_count_hi", count[127:64], 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_snap_done", 64'(snap_done), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_snap_ovf", 64'(snap_ovf), 64'd0);
    up = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
